// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared states, widths and index order for mux_sel_sequencer
// Index order is selected by MUX_SEQ_MSB_FIRST_EN (undefined: LSB first).
package mux_seq_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

`ifdef MUX_SEQ_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] SEL_FIRST = 3'd7;
  localparam logic [SEL_W-1:0] SEL_LAST  = 3'd0;

  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] s);
    return s - SEL_W'(1);
  endfunction
`else
  localparam logic [SEL_W-1:0] SEL_FIRST = 3'd0;
  localparam logic [SEL_W-1:0] SEL_LAST  = 3'd7;

  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] s);
    return s + SEL_W'(1);
  endfunction
`endif

endpackage

// File: rtl/mux_seq_gap_cnt.sv
// rtl/mux_seq_gap_cnt.sv - loadable down-counter timing the inter-frame gap
// done_o is high whenever the count has reached zero.
module mux_seq_gap_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - holds a word on an 8:1 mux and steps its select to serialize it
// Index direction follows MUX_SEQ_MSB_FIRST_EN (see mux_seq_pkg).
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned GAP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] mux_a,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic              mux_f,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);

  localparam int unsigned GAP_W = 4;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              rdy_q, rdy_d;
  logic              bit_q, valid_q, last_q;
  logic              xfer;
  logic              gap_done;

  assign xfer = in_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    a_d     = a_q;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_SHIFT;
          sel_d   = SEL_FIRST;
          a_d     = in_data;
        end
      end
      ST_SHIFT: begin
        if (sel_q != SEL_LAST) begin
          sel_d = sel_step(sel_q);
        end else if (GAP > 0) begin
          state_d = ST_GAP;
        end else if (xfer) begin
          sel_d = SEL_FIRST;
          a_d   = in_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Ready is registered, so it is derived from where the FSM will be next cycle.
    rdy_d = (state_d == ST_IDLE) ||
            ((GAP == 0) && (state_d == ST_SHIFT) && (sel_d == SEL_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      a_q     <= '0;
      rdy_q   <= 1'b0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      rdy_q   <= rdy_d;
      valid_q <= (state_q == ST_SHIFT);
      last_q  <= (state_q == ST_SHIFT) && (sel_q == SEL_LAST);
      if (state_q == ST_SHIFT) begin
        bit_q <= mux_f;
      end
    end
  end

  generate
    if (GAP > 0) begin : g_gap
      mux_seq_gap_cnt #(.CNT_W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     ((state_q == ST_SHIFT) && (state_d == ST_GAP)),
        .load_val_i (GAP_W'(GAP - 1)),
        .dec_i      (state_q == ST_GAP),
        .done_o     (gap_done)
      );
    end else begin : g_no_gap
      assign gap_done = 1'b1;
    end
  endgenerate

  assign in_ready  = rdy_q;
  assign mux_a     = a_q;
  assign mux_sel   = sel_q;
  assign ser_bit   = bit_q;
  assign ser_valid = valid_q;
  assign ser_last  = last_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - self-checking bench for mux_sel_sequencer (GAP=0 and GAP=3 instances)
// The reference model tracks each instance by cycles elapsed since its last accepted word.
module tb_mux_sel_sequencer;

  localparam int GAP0 = 0;
  localparam int GAP1 = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] in_valid, in_ready, mux_f, ser_bit, ser_valid, ser_last, busy;
  logic [7:0] in_data [2];
  logic [7:0] mux_a [2];
  logic [2:0] mux_sel [2];

  int n_checks = 0;
  int n_errors = 0;

  bit         have [2];
  int         k [2];
  int         since_rst [2];
  logic [7:0] word [2];
  bit         exp_sv [2], exp_sb [2], exp_sl [2];
  bit         xfer_seen [2];
  int         idx [2];
  logic [7:0] words [4];

  always #5 clk = ~clk;

  assign mux_f[0] = mux_a[0][mux_sel[0]];
  assign mux_f[1] = mux_a[1][mux_sel[1]];

  mux_sel_sequencer #(.GAP(GAP0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .mux_a(mux_a[0]), .mux_sel(mux_sel[0]), .mux_f(mux_f[0]),
    .ser_bit(ser_bit[0]), .ser_valid(ser_valid[0]), .ser_last(ser_last[0]), .busy(busy[0])
  );

  mux_sel_sequencer #(.GAP(GAP1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .mux_a(mux_a[1]), .mux_sel(mux_sel[1]), .mux_f(mux_f[1]),
    .ser_bit(ser_bit[1]), .ser_valid(ser_valid[1]), .ser_last(ser_last[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP0 : GAP1;
  endfunction

  // Position j (0..7) within a frame mapped to the mux index it presents.
  function automatic int ord(input int j);
`ifdef MUX_SEQ_MSB_FIRST_EN
    return 7 - j;
`else
    return j;
`endif
  endfunction

  function automatic bit m_ready(input int i);
    if (!have[i]) return since_rst[i] >= 1;
    return k[i] >= ((gap_of(i) == 0) ? 8 : 9 + gap_of(i));
  endfunction

  task automatic model_reset(input int i);
    have[i] = 1'b0; k[i] = 0; since_rst[i] = 0; word[i] = 8'h00;
    exp_sv[i] = 1'b0; exp_sb[i] = 1'b0; exp_sl[i] = 1'b0; xfer_seen[i] = 1'b0;
  endtask

  task automatic model_edge(input int i);
    bit pv, pb, pl, rdy;
    xfer_seen[i] = 1'b0;
    if (!rst_n) begin
      model_reset(i);
      return;
    end
    pv  = have[i] && (k[i] >= 1) && (k[i] <= 8);
    pb  = pv ? word[i][ord(k[i] - 1)] : 1'b0;
    pl  = pv && (k[i] == 8);
    rdy = m_ready(i);
    if (in_valid[i] && rdy) begin
      xfer_seen[i] = 1'b1;
      have[i] = 1'b1;
      word[i] = in_data[i];
      k[i] = 1;
    end else if (k[i] < 1000) begin
      k[i]++;
    end
    if (since_rst[i] < 1000) since_rst[i]++;
    exp_sv[i] = pv; exp_sb[i] = pb; exp_sl[i] = pl;
  endtask

  task automatic model_check(input int i);
    bit in_frame;
    in_frame = have[i] && (k[i] >= 1) && (k[i] <= 8);
    check($sformatf("in_ready%0d", i), in_ready[i], m_ready(i));
    check($sformatf("busy%0d", i), busy[i], have[i] && (k[i] >= 1) && (k[i] <= 8 + gap_of(i)));
    check($sformatf("mux_a%0d", i), mux_a[i], have[i] ? word[i] : 8'h00);
    if (in_frame) check($sformatf("mux_sel%0d", i), mux_sel[i], ord(k[i] - 1));
    else if (!have[i]) check($sformatf("mux_sel_rst%0d", i), mux_sel[i], 0);
    check($sformatf("ser_valid%0d", i), ser_valid[i], exp_sv[i]);
    check($sformatf("ser_last%0d", i), ser_last[i], exp_sl[i]);
    if (exp_sv[i]) check($sformatf("ser_bit%0d", i), ser_bit[i], exp_sb[i]);
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    for (int i = 0; i < 2; i++) model_check(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_in_ready%0d", i), in_ready[i], 0);
      check($sformatf("rst_mux_a%0d", i), mux_a[i], 0);
      check($sformatf("rst_mux_sel%0d", i), mux_sel[i], 0);
      check($sformatf("rst_ser_bit%0d", i), ser_bit[i], 0);
      check($sformatf("rst_ser_valid%0d", i), ser_valid[i], 0);
      check($sformatf("rst_ser_last%0d", i), ser_last[i], 0);
      check($sformatf("rst_busy%0d", i), busy[i], 0);
      model_reset(i);
    end
    repeat (2) cycle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    words[0] = 8'hA5; words[1] = 8'hFF; words[2] = 8'h00; words[3] = 8'h01;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = 8'h00;
      idx[i]      = 0;
      model_reset(i);
    end
    #2;
    do_reset();

    // Directed: words offered continuously, exercising back-to-back and gapped framing.
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = (idx[i] < 4);
        in_data[i]  = (idx[i] < 4) ? words[idx[i]] : 8'h00;
      end
      cycle();
      for (int i = 0; i < 2; i++) if (xfer_seen[i]) idx[i]++;
    end
    for (int i = 0; i < 2; i++) check($sformatf("directed_words%0d", i), idx[i], 4);

    // Random: valid and data change every cycle, including while not ready.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = ($urandom_range(0, 2) != 0);
        in_data[i]  = 8'($urandom);
      end
      cycle();
    end

    // Reset mid-frame once four bits of instance 0 have been emitted.
    begin
      int waited;
      waited = 0;
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = 1'b1;
        in_data[i]  = 8'($urandom);
      end
      while (!(have[0] && k[0] == 5) && waited < 40) begin
        cycle();
        waited++;
      end
      check("mid_frame_reached", (have[0] && k[0] == 5), 1);
      for (int i = 0; i < 2; i++) in_valid[i] = 1'b0;
      do_reset();
    end

    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i] = ($urandom_range(0, 3) != 0);
        in_data[i]  = 8'($urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
